// File: rtl/ap_ctrl_arb_pkg.sv
// Shared types and helpers for the ap_ctrl_hs sharing arbiter.
package ap_ctrl_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counters up to 64 bits wide share one saturating incrementer; w is the live width.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] maxv;
    maxv = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    return (v >= maxv) ? maxv : v + 64'd1;
  endfunction

endpackage

// File: rtl/ap_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module ap_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx
);

  // Scan from the farthest offset down so the nearest request overwrites the rest.
  always_comb begin
    int                 idx;
    logic [IDX_W-1:0]   cand;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDX_W'(idx);
      if (req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/ap_ctrl_arbiter.sv
// Shares one ap_ctrl_hs kernel between NUM_REQ requesters, one transaction at a time.
// Optional performance counters are built when AP_CTRL_ARB_PERF_EN is defined.
module ap_ctrl_arbiter
  import ap_ctrl_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 32
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        req_done,
  output logic                      k_ap_start,
  input  logic                      k_ap_ready,
  input  logic                      k_ap_done,
  input  logic                      k_ap_idle,
  output logic [idx_w(NUM_REQ)-1:0] owner,
  output logic                      busy,
  output logic                      proto_err,
  output logic [CNT_W-1:0]          last_latency,
  output logic [CNT_W-1:0]          txn_count
);

  localparam int IDX_W = idx_w(NUM_REQ);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_inc, pick_ptr, gnt_idx;
  logic             gnt_valid;
  logic             proto_err_q, proto_err_d;

  assign owner_inc = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  // In DONE the just-served requester drops to lowest priority before the pointer register updates.
  assign pick_ptr = (state_q == DONE) ? owner_inc : rr_ptr_q;

  ap_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req       (req_valid),
    .ptr       (pick_ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    k_ap_start = 1'b0;
    req_ready  = '0;
    req_done   = '0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          owner_d = gnt_idx;
          state_d = START;
        end
      end
      START: begin
        k_ap_start = 1'b1;
        if (k_ap_ready) begin
          req_ready[owner_q] = 1'b1;
          state_d = k_ap_done ? DONE : RUN;
        end
      end
      RUN: begin
        if (k_ap_done) state_d = DONE;
      end
      DONE: begin
        req_done[owner_q] = 1'b1;
        rr_ptr_d = owner_inc;
        if (gnt_valid) begin
          owner_d = gnt_idx;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign proto_err_d = proto_err_q | ((state_q == IDLE) & (k_ap_done | ~k_ap_idle));

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign owner     = owner_q;
  assign busy      = (state_q != IDLE);
  assign proto_err = proto_err_q;

`ifdef AP_CTRL_ARB_PERF_EN
  logic [CNT_W-1:0] cyc_q, cyc_d, lat_q, lat_d, txn_q, txn_d;

  // Latency counts every START/RUN cycle up to and including the ap_done cycle.
  always_comb begin
    cyc_d = cyc_q;
    lat_d = lat_q;
    txn_d = txn_q;
    if ((state_d == START) && (state_q != START)) begin
      cyc_d = '0;
    end else if ((state_q == START) || (state_q == RUN)) begin
      cyc_d = CNT_W'(sat_inc(64'(cyc_q), CNT_W));
    end
    if (state_q == DONE) begin
      lat_d = cyc_q;
      txn_d = CNT_W'(sat_inc(64'(txn_q), CNT_W));
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cyc_q <= '0;
      lat_q <= '0;
      txn_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      lat_q <= lat_d;
      txn_q <= txn_d;
    end
  end

  assign last_latency = lat_q;
  assign txn_count    = txn_q;
`else
  assign last_latency = '0;
  assign txn_count    = '0;
`endif

endmodule

// File: doc/ap_ctrl_arbiter.md
# ap_ctrl_arbiter

Sequencing controller that shares one `ap_ctrl_hs` HLS kernel instance between `NUM_REQ` requesters. It arbitrates round-robin, drives the kernel's `ap_start`, and tracks `ap_ready` and `ap_done`. It steers argument muxing through an owner index. Each transaction runs to completion before the next begins. The block sits between the testbench/host-side requesters and the kernel top.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters, 2..16.
- `CNT_W`, 32: width of the performance counters.

Ports:
- `ap_clk` in 1: the single clock.
- `ap_rst_n` in 1: asynchronous active-low reset.
- `req_valid` in `NUM_REQ`: per-requester transaction request. Held high until `req_ready`.
- `req_ready` out `NUM_REQ`: one-cycle pulse when the kernel accepts the requester's job.
- `req_done` out `NUM_REQ`: one-cycle pulse when that job's `ap_done` has been seen.
- `k_ap_start` out 1: kernel start.
- `k_ap_ready` in 1: kernel ready.
- `k_ap_done` in 1: kernel done.
- `k_ap_idle` in 1: kernel idle. Used only for the sanity flag.
- `owner` out `$clog2(NUM_REQ)`: index of the current/last granted requester. Valid from START through DONE.
- `busy` out 1: high in any state other than IDLE.
- `proto_err` out 1: sticky. Set if `k_ap_done` is high while in IDLE, or `k_ap_idle` is low while in IDLE. Cleared only by reset.
- `last_latency` out `CNT_W`: cycles of the last transaction (perf feature).
- `txn_count` out `CNT_W`: completed transactions (perf feature).

## Operation

- FSM states: IDLE, START, RUN, DONE.
- **IDLE:** if any `req_valid` is high, pick the winner round-robin. Search begins at `rr_ptr` and proceeds upward with wrap. Register the winner into `owner` and go to START.
- **START:** `k_ap_start`=1.
  - On `k_ap_ready`=1, pulse `req_ready[owner]` in the same cycle.
  - If `k_ap_done` is also 1 in that cycle, go to DONE; otherwise go to RUN.
  - `req_valid[owner]` deasserting in START is ignored; the start is never retracted.
- **RUN:** `k_ap_start`=0. On `k_ap_done`=1, go to DONE.
- **DONE:** `req_done[owner]`=1 for this cycle.
  - Set `rr_ptr` to `owner`+1 (mod `NUM_REQ`).
  - Arbitrate again using the updated pointer. Go to START with the new owner if any `req_valid` is high, else go to IDLE.
  - The requester just serviced has the lowest priority.
- Round-robin pointer wraps from `NUM_REQ`-1 to 0.
- `k_ap_ready` or `k_ap_done` seen outside the states above is ignored, apart from the `proto_err` rule.
- Reset values:
  - state IDLE; `rr_ptr` 0; `owner` 0.
  - all outputs 0.
  - counters 0.

## Timing

- `req_valid` high at cycle 0 in IDLE: START in cycle 1, `k_ap_start` high from cycle 1.
- `k_ap_ready` at cycle r:
  - `req_ready` pulses at r.
  - `k_ap_start` is low from r+1, unless r is also the done cycle and a new request is pending.
- `k_ap_done` at cycle d: DONE and `req_done` at d+1.
- Back-to-back: with a request pending, the next `k_ap_start` rises at d+2.
- `req_ready` and `req_done` are never asserted for more than one requester at a time.
- Reset asserted mid-transaction:
  - all outputs drop to 0 asynchronously.
  - the pending job is lost; no `req_done` is issued.
  - the kernel must share the same reset.

## Configuration

- Macro: `AP_CTRL_ARB_PERF_EN`.
- **Defined:**
  - A cycle counter clears on entry to START and increments every cycle through the `k_ap_done` cycle, inclusive.
  - In DONE, `last_latency` gets the count and `txn_count` increments.
  - Both saturate at all-ones.
- **Undefined:** counters are not built; `last_latency` and `txn_count` are tied to 0.

## Structure

- Package `ap_ctrl_arb_pkg`:
  - state enum `arb_state_e` (IDLE, START, RUN, DONE).
  - index-width helper function.
  - saturating-increment function.
- Sub-module `ap_rr_pick`: combinational round-robin pick.
  - Inputs: `req` vector and `ptr`.
  - Outputs: `gnt_valid` and `gnt_idx`.
  - Instantiated once and used in both IDLE and DONE.

## Test plan

- **Single request:** `req_valid[2]` at cycle 0, `k_ap_ready` at cycle 1, `k_ap_done` at cycle 5.
  - `k_ap_start` high in cycle 1 only.
  - `req_ready[2]` at cycle 1; `req_done[2]` at cycle 6.
  - `last_latency`=5, `txn_count`=1.
- **All four requesting continuously:** grants in order 0,1,2,3,0.
  - Next start 2 cycles after each `req_done`'s preceding done.
- **`k_ap_ready` delayed 3 cycles:** `k_ap_start` held high for 4 cycles; `req_ready` pulses once, at the ready cycle.
- **`k_ap_ready` and `k_ap_done` in the same cycle:** FSM goes START→DONE; `req_done` the following cycle.
- **`ap_rst_n` low during RUN:**
  - outputs 0 immediately; no `req_done`.
  - after release, `req_valid[1]` is granted with `rr_ptr`=0 behaviour.
- **`k_ap_done` pulse while IDLE:** `proto_err` rises next cycle and stays high until reset.
